// File: rtl/sync_fifo_flags_if.sv
// Bundle of the FIFO's producer/consumer-facing signals.
//
// master : the block driving the FIFO (flush, write/read requests, write data)
// slave  : the FIFO itself (read data, occupancy, flags, error pulses)
//
// Signals:
//   clr       synchronous flush
//   wr_en     write request
//   rd_en     read request (read acknowledge in FWFT mode)
//   data_in   write data
//   data_out  read data
//   f_empty   count == 0
//   f_full    count == depth
//   f_afull   count >= almost-full threshold
//   f_aempty  count <= almost-empty threshold
//   count     current occupancy, 0..depth
//   overflow  one-cycle pulse: a write was rejected
//   underflow one-cycle pulse: a read was rejected
interface sync_fifo_flags_if #(
    parameter int unsigned DATAWIDTH = 8,
    parameter int unsigned ADDRWIDTH = 4
);
    logic                 clr;
    logic                 wr_en;
    logic                 rd_en;
    logic [DATAWIDTH-1:0] data_in;
    logic [DATAWIDTH-1:0] data_out;
    logic                 f_empty;
    logic                 f_full;
    logic                 f_afull;
    logic                 f_aempty;
    logic [ADDRWIDTH:0]   count;
    logic                 overflow;
    logic                 underflow;

    modport master (
        output clr,
        output wr_en,
        output rd_en,
        output data_in,
        input  data_out,
        input  f_empty,
        input  f_full,
        input  f_afull,
        input  f_aempty,
        input  count,
        input  overflow,
        input  underflow
    );

    modport slave (
        input  clr,
        input  wr_en,
        input  rd_en,
        input  data_in,
        output data_out,
        output f_empty,
        output f_full,
        output f_afull,
        output f_aempty,
        output count,
        output overflow,
        output underflow
    );
endinterface

// File: rtl/sync_fifo_flags.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// flags, overflow/underflow error pulses, synchronous flush and an optional
// first-word-fall-through read mode.
//
// Ports:
//   clk  rising-edge clock for all state
//   rst  asynchronous active-high reset (pointers, count, data_out, error pulses)
//   bus  sync_fifo_flags_if slave modport:
//        clr/wr_en/rd_en/data_in in; data_out, count, f_* flags,
//        overflow/underflow out
//
// Flags are decoded from the registered count only, so nothing on the request
// inputs reaches a flag or the count combinationally.
module sync_fifo_flags #(
    parameter int unsigned DATAWIDTH     = 8,
    parameter int unsigned ADDRWIDTH     = 4,
    parameter int unsigned ADDRDEPTH     = 16,
    parameter int unsigned AFULL_THRESH  = 12,
    parameter int unsigned AEMPTY_THRESH = 4,
    parameter bit          FWFT          = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    sync_fifo_flags_if.slave    bus
);

    // Elaboration-time parameter sanity checks.
    if (ADDRDEPTH != (1 << ADDRWIDTH)) begin : g_bad_depth
        $error("sync_fifo_flags: ADDRDEPTH must equal 2**ADDRWIDTH");
    end
    if (AFULL_THRESH < 1 || AFULL_THRESH > ADDRDEPTH - 1) begin : g_bad_afull
        $error("sync_fifo_flags: AFULL_THRESH must be in 1..ADDRDEPTH-1");
    end
    if (AEMPTY_THRESH >= AFULL_THRESH) begin : g_bad_aempty
        $error("sync_fifo_flags: AEMPTY_THRESH must be below AFULL_THRESH");
    end

    localparam logic [ADDRWIDTH:0] DepthCnt  = ADDRDEPTH[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] AfullCnt  = AFULL_THRESH[ADDRWIDTH:0];
    localparam logic [ADDRWIDTH:0] AemptyCnt = AEMPTY_THRESH[ADDRWIDTH:0];

    // Pointers carry one extra bit and simply wrap modulo 2*depth; the count
    // register, not the pointer MSBs, is the source of truth for full/empty.
    logic [ADDRWIDTH:0]   wptr_q, wptr_d;
    logic [ADDRWIDTH:0]   rptr_q, rptr_d;
    logic [ADDRWIDTH:0]   count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic                 udf_q, udf_d;

    logic [DATAWIDTH-1:0] mem [ADDRDEPTH];

    logic                 full;
    logic                 empty;
    logic                 wr_acc;
    logic                 rd_acc;

    assign full  = (count_q == DepthCnt);
    assign empty = (count_q == '0);

    // Flush wins over both requests: nothing is accepted on a clr edge.
    assign wr_acc = bus.wr_en & ~full  & ~bus.clr;
    assign rd_acc = bus.rd_en & ~empty & ~bus.clr;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = 1'b0;
        udf_d   = 1'b0;

        if (bus.clr) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            // A read on a full FIFO frees no space for the same-edge write, and a
            // write on an empty FIFO cannot be read back on the same edge.
            ovf_d = bus.wr_en & full;
            udf_d = bus.rd_en & empty;

            if (wr_acc) begin
                wptr_d = wptr_q + 1'b1;
            end
            if (rd_acc) begin
                rptr_d = rptr_q + 1'b1;
            end

            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage array is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q[ADDRWIDTH-1:0]] <= bus.data_in;
        end
    end

    // ------------------------------------------------------------------
    // Read data path
    // ------------------------------------------------------------------
    if (FWFT) begin : g_fwft
        // Head word is always presented; rd_en acknowledges and pops it.
        assign bus.data_out = mem[rptr_q[ADDRWIDTH-1:0]];
    end else begin : g_std
        logic [DATAWIDTH-1:0] dout_q;

        // Loads only on an accepted read; holds through rejected reads and flush.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (rd_acc) begin
                dout_q <= mem[rptr_q[ADDRWIDTH-1:0]];
            end
        end

        assign bus.data_out = dout_q;
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.count     = count_q;
    assign bus.f_empty   = empty;
    assign bus.f_full    = full;
    assign bus.f_afull   = (count_q >= AfullCnt);
    assign bus.f_aempty  = (count_q <= AemptyCnt);
    assign bus.overflow  = ovf_q;
    assign bus.underflow = udf_q;

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: one standard-read and one FWFT instance driven by
// identical stimulus, checked every cycle against a queue-based model, plus
// directed literal expectations for each scenario.
module tb_sync_fifo_flags;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clr_s = 1'b0;
    logic       wr = 1'b0;
    logic       rd = 1'b0;
    logic [7:0] din = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_flags_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus_std ();
    sync_fifo_flags_if #(.DATAWIDTH(8), .ADDRWIDTH(4)) bus_fw ();

    assign bus_std.clr     = clr_s;
    assign bus_std.wr_en   = wr;
    assign bus_std.rd_en   = rd;
    assign bus_std.data_in = din;
    assign bus_fw.clr      = clr_s;
    assign bus_fw.wr_en    = wr;
    assign bus_fw.rd_en    = rd;
    assign bus_fw.data_in  = din;

    sync_fifo_flags #(
        .DATAWIDTH(8), .ADDRWIDTH(4), .ADDRDEPTH(16),
        .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1'b0)
    ) u_std (
        .clk(clk),
        .rst(rst),
        .bus(bus_std)
    );

    sync_fifo_flags #(
        .DATAWIDTH(8), .ADDRWIDTH(4), .ADDRDEPTH(16),
        .AFULL_THRESH(12), .AEMPTY_THRESH(4), .FWFT(1'b1)
    ) u_fw (
        .clk(clk),
        .rst(rst),
        .bus(bus_fw)
    );

    // ---------------- model ----------------
    logic [7:0] q[$];
    logic       m_ovf = 1'b0;
    logic       m_udf = 1'b0;
    logic [7:0] m_dout = 8'h00;
    bit         check_en = 1'b0;
    int         n_checks = 0;
    int         n_pass = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endfunction

    function automatic void model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = 8'h00;
    endfunction

    // Applies the request sampled on one clock edge to the queue model.
    function automatic void model_step();
        int n;
        n = q.size();
        if (clr_s) begin
            q.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_ovf = wr && (n == 16);
            m_udf = rd && (n == 0);
            if (rd && n != 0) m_dout = q.pop_front();
            if (wr && n != 16) q.push_back(din);
        end
    endfunction

    task automatic cyc(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr = w;
        rd = r;
        din = d;
        clr_s = c;
        @(posedge clk);
        model_step();
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        clr_s = 1'b0;
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (check_en && !rst) begin
            int n;
            n = q.size();
            check("std count",    32'(bus_std.count),     32'(n));
            check("fw count",     32'(bus_fw.count),      32'(n));
            check("std empty",    32'(bus_std.f_empty),   32'(n == 0));
            check("fw empty",     32'(bus_fw.f_empty),    32'(n == 0));
            check("std full",     32'(bus_std.f_full),    32'(n == 16));
            check("fw full",      32'(bus_fw.f_full),     32'(n == 16));
            check("std afull",    32'(bus_std.f_afull),   32'(n >= 12));
            check("fw afull",     32'(bus_fw.f_afull),    32'(n >= 12));
            check("std aempty",   32'(bus_std.f_aempty),  32'(n <= 4));
            check("fw aempty",    32'(bus_fw.f_aempty),   32'(n <= 4));
            check("std overflow", 32'(bus_std.overflow),  32'(m_ovf));
            check("fw overflow",  32'(bus_fw.overflow),   32'(m_ovf));
            check("std underflow", 32'(bus_std.underflow), 32'(m_udf));
            check("fw underflow", 32'(bus_fw.underflow),  32'(m_udf));
            check("std data_out", 32'(bus_std.data_out),  32'(m_dout));
            if (n != 0) check("fw data_out", 32'(bus_fw.data_out), 32'(q[0]));
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, " count"},     32'(bus_std.count),     32'd0);
        check({tag, " empty"},     32'(bus_std.f_empty),   32'd1);
        check({tag, " aempty"},    32'(bus_std.f_aempty),  32'd1);
        check({tag, " full"},      32'(bus_std.f_full),    32'd0);
        check({tag, " afull"},     32'(bus_std.f_afull),   32'd0);
        check({tag, " overflow"},  32'(bus_std.overflow),  32'd0);
        check({tag, " underflow"}, 32'(bus_std.underflow), 32'd0);
        check({tag, " data_out"},  32'(bus_std.data_out),  32'd0);
        check({tag, " fw count"},  32'(bus_fw.count),      32'd0);
        check({tag, " fw empty"},  32'(bus_fw.f_empty),    32'd1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        rst = 1'b0;
        check_en = 1'b1;

        // 1: fill 1..16, then a rejected 17th write.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b1, 1'b0, 8'(i), 1'b0);
            check("t1 count",  32'(bus_std.count),    32'(i));
            check("t1 aempty", 32'(bus_std.f_aempty), 32'(i <= 4));
            check("t1 afull",  32'(bus_std.f_afull),  32'(i >= 12));
        end
        check("t1 full", 32'(bus_std.f_full), 32'd1);
        cyc(1'b1, 1'b0, 8'd17, 1'b0);
        check("t1 overflow", 32'(bus_std.overflow), 32'd1);
        check("t1 count17",  32'(bus_std.count),    32'd16);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        check("t1 overflow drop", 32'(bus_std.overflow), 32'd0);

        // 2: drain 1..16, then a rejected read.
        for (int i = 1; i <= 16; i++) begin
            cyc(1'b0, 1'b1, 8'd0, 1'b0);
            check("t2 data", 32'(bus_std.data_out), 32'(i));
            check("t2 count", 32'(bus_std.count),   32'(16 - i));
        end
        check("t2 empty", 32'(bus_std.f_empty), 32'd1);
        cyc(1'b0, 1'b1, 8'd0, 1'b0);
        check("t2 underflow", 32'(bus_std.underflow), 32'd1);
        check("t2 data hold", 32'(bus_std.data_out),  32'd16);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        check("t2 underflow drop", 32'(bus_std.underflow), 32'd0);

        // 3: steady-state at count 5 across two pointer wraps.
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 8'(100 + i), 1'b0);
        for (int k = 0; k < 40; k++) begin
            cyc(1'b1, 1'b1, 8'(105 + k), 1'b0);
            check("t3 count", 32'(bus_std.count),     32'd5);
            check("t3 data",  32'(bus_std.data_out),  32'(100 + k));
            check("t3 ovf",   32'(bus_std.overflow),  32'd0);
            check("t3 udf",   32'(bus_std.underflow), 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 1'b1, 8'd0, 1'b0);
            check("t3 drain", 32'(bus_std.data_out), 32'(140 + i));
        end

        // 4: simultaneous requests at full and at empty.
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 8'(50 + i), 1'b0);
        cyc(1'b1, 1'b1, 8'd99, 1'b0);
        check("t4 full count", 32'(bus_std.count),    32'd15);
        check("t4 overflow",   32'(bus_std.overflow), 32'd1);
        check("t4 head",       32'(bus_std.data_out), 32'd50);
        for (int i = 1; i <= 15; i++) begin
            cyc(1'b0, 1'b1, 8'd0, 1'b0);
            check("t4 drain", 32'(bus_std.data_out), 32'(50 + i));
        end
        check("t4 empty", 32'(bus_std.f_empty), 32'd1);
        cyc(1'b1, 1'b1, 8'd77, 1'b0);
        check("t4 empty count", 32'(bus_std.count),     32'd1);
        check("t4 underflow",   32'(bus_std.underflow), 32'd1);
        cyc(1'b0, 1'b1, 8'd0, 1'b0);
        check("t4 data 77", 32'(bus_std.data_out), 32'd77);

        // 5: FWFT fall-through and pop.
        cyc(1'b1, 1'b0, 8'hA5, 1'b0);
        check("t5 fw data",  32'(bus_fw.data_out), 32'hA5);
        check("t5 fw empty", 32'(bus_fw.f_empty),  32'd0);
        cyc(1'b0, 1'b0, 8'd0, 1'b0);
        check("t5 fw hold",  32'(bus_fw.data_out), 32'hA5);
        cyc(1'b0, 1'b1, 8'd0, 1'b0);
        check("t5 fw empty after pop", 32'(bus_fw.f_empty), 32'd1);
        check("t5 fw count", 32'(bus_fw.count), 32'd0);

        // 6: flush at count 7, then async reset mid-cycle at count 9.
        for (int i = 0; i < 7; i++) cyc(1'b1, 1'b0, 8'(i + 1), 1'b0);
        check("t6 count7", 32'(bus_std.count), 32'd7);
        cyc(1'b1, 1'b0, 8'hEE, 1'b1);
        check("t6 clr count", 32'(bus_std.count),    32'd0);
        check("t6 clr empty", 32'(bus_std.f_empty),  32'd1);
        check("t6 clr ovf",   32'(bus_std.overflow), 32'd0);
        check("t6 clr hold",  32'(bus_std.data_out), 32'hA5);
        for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, 8'(200 + i), 1'b0);
        check("t6 count9", 32'(bus_std.count), 32'd9);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_values("t6 rst");
        @(negedge clk);
        rst = 1'b0;
        cyc(1'b1, 1'b0, 8'h3C, 1'b0);
        cyc(1'b0, 1'b1, 8'd0, 1'b0);
        check("t6 recover data", 32'(bus_std.data_out), 32'h3C);
        check("t6 recover empty", 32'(bus_std.f_empty), 32'd1);

        check_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
